stage_flag_gen: RTL and testbench

- Produces the 3-bit `next_stage_flag` command consumed by the game stage-sequencing FSM (OPENING/STAGE1/STAGE2/STAGE3/FINISH).
- Turns player buttons and game events into exactly one legal transition code per event.
- Holds each code until `cur_stage` confirms the transition, or until a timeout expires.
- Also drives the stage-select value shown on the opening screen.

---
 rtl/stage_flag_gen.sv | 172 +++++++++++++++++
 tb/tb_stage_flag_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_flag_gen.sv
// Stage transition command generator for the game stage FSM.
// Optional button debounce filter: define BTN_DEBOUNCE_EN.
module stage_flag_gen #(
  parameter int FINISH_HOLD     = 50000000,
  parameter int ACK_TIMEOUT     = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_sel,
  input  logic       stage_end,
  input  logic [2:0] cur_stage,
  output logic [2:0] next_stage_flag,
  output logic [1:0] sel_stage,
  output logic       busy,
  output logic       ack_err
);

  localparam logic [2:0] OPENING = 3'd0;
  localparam logic [2:0] STAGE1  = 3'd1;
  localparam logic [2:0] STAGE2  = 3'd2;
  localparam logic [2:0] STAGE3  = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  localparam int HW = (FINISH_HOLD > 1) ? $clog2(FINISH_HOLD) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(FINISH_HOLD - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [1:0] s1, s2, filt, fprev, rise;
  logic       start_e, sel_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      fprev <= '0;
    end else begin
      s1    <= {btn_sel, btn_start};
      s2    <= s1;
      fprev <= filt;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] dcnt [2];

  // Output follows the sample only after a full run of equal samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt    <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          filt[i] <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_db;
  assign unused_db = |DEBOUNCE_CYCLES;
  assign filt      = s2;
`endif

  assign rise    = filt & ~fprev;
  assign start_e = rise[0];
  assign sel_e   = rise[1];

  state_t          state, state_n;
  logic [2:0]      flag_n, exp_stage, exp_n;
  logic [1:0]      sel_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [AW-1:0]   wcnt, wcnt_n;
  logic            err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      next_stage_flag <= '0;
      sel_stage       <= 2'd1;
      exp_stage       <= '0;
      hcnt            <= '0;
      wcnt            <= '0;
      ack_err         <= 1'b0;
    end else begin
      state           <= state_n;
      next_stage_flag <= flag_n;
      sel_stage       <= sel_n;
      exp_stage       <= exp_n;
      hcnt            <= hcnt_n;
      wcnt            <= wcnt_n;
      ack_err         <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    flag_n  = next_stage_flag;
    sel_n   = sel_stage;
    exp_n   = exp_stage;
    hcnt_n  = '0;
    wcnt_n  = wcnt;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        flag_n = '0;
        wcnt_n = '0;
        unique case (1'b1)
          (cur_stage == OPENING): begin
            if (start_e) begin
              flag_n  = {1'b0, sel_stage};
              exp_n   = {1'b0, sel_stage};
              state_n = ISSUE;
            end else if (sel_e) begin
              sel_n = (sel_stage == 2'd3) ? 2'd1 : sel_stage + 2'd1;
            end
          end
          (cur_stage == STAGE1),
          (cur_stage == STAGE2),
          (cur_stage == STAGE3): begin
            if (stage_end) begin
              flag_n  = cur_stage + 3'd3;
              exp_n   = FINISH;
              state_n = ISSUE;
            end
          end
          (cur_stage == FINISH): begin
            if (start_e || hcnt == HOLD_LAST) begin
              flag_n  = 3'b111;
              exp_n   = OPENING;
              state_n = ISSUE;
            end else begin
              hcnt_n = hcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
      ISSUE: begin
        if (cur_stage == exp_stage) begin
          flag_n  = '0;
          state_n = IDLE;
        end else if (wcnt == ACK_LAST) begin
          flag_n  = '0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ISSUE);

endmodule

// File: tb/tb_stage_flag_gen.sv
// Bench for stage_flag_gen: directed vectors plus a cycle-level
// reference model compared on every falling clock edge.
module tb_stage_flag_gen;

  localparam int FH = 8;
  localparam int AT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_sel = 1'b0;
  logic       stage_end = 1'b0;
  logic [2:0] cur_stage = 3'd0;
  logic [2:0] next_stage_flag;
  logic [1:0] sel_stage;
  logic       busy;
  logic       ack_err;

  int n_tests = 0;
  int n_fail  = 0;

  stage_flag_gen #(
    .FINISH_HOLD(FH),
    .ACK_TIMEOUT(AT),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start(btn_start),
    .btn_sel(btn_sel),
    .stage_end(stage_end),
    .cur_stage(cur_stage),
    .next_stage_flag(next_stage_flag),
    .sel_stage(sel_stage),
    .busy(busy),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, got, want, $time);
    end
  endtask

  // Reference model: raw button history and time stamps of events.
  int       m_flag = 0;
  int       m_sel  = 1;
  bit       m_busy = 0;
  bit       m_err  = 0;
  int       m_exp  = 0;
  int       cyc    = 0;
  int       t_issue = 0;
  int       t_fin  = 0;
  bit       counting = 0;
  bit [2:0] hs = '0;
  bit [2:0] hl = '0;

  always @(posedge clk or negedge reset) begin
    bit es, el;
    if (!reset) begin
      m_flag = 0; m_sel = 1; m_busy = 0; m_err = 0;
      hs = '0; hl = '0; counting = 0;
    end else begin
      cyc++;
      es = hs[1] & ~hs[2];
      el = hl[1] & ~hl[2];
      hs = {hs[1:0], btn_start};
      hl = {hl[1:0], btn_sel};
      m_err = 0;
      if (m_busy) begin
        counting = 0;
        if (int'(cur_stage) == m_exp) begin
          m_busy = 0; m_flag = 0;
        end else if (cyc - t_issue == AT) begin
          m_busy = 0; m_flag = 0; m_err = 1;
        end
      end else if (cur_stage == 3'd0) begin
        counting = 0;
        if (es) begin
          m_flag = m_sel; m_exp = m_sel;
          m_busy = 1; t_issue = cyc;
        end else if (el) begin
          m_sel = m_sel % 3 + 1;
        end
      end else if (cur_stage <= 3'd3) begin
        counting = 0;
        if (stage_end) begin
          m_flag = int'(cur_stage) + 3; m_exp = 4;
          m_busy = 1; t_issue = cyc;
        end
      end else if (cur_stage == 3'd4) begin
        if (!counting) begin
          counting = 1; t_fin = cyc;
        end
        if (es || cyc - t_fin + 1 == FH) begin
          m_flag = 7; m_exp = 0;
          m_busy = 1; t_issue = cyc;
          counting = 0;
        end
      end else begin
        counting = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_flag", int'(next_stage_flag), m_flag);
    chk("m_sel", int'(sel_stage), m_sel);
    chk("m_busy", int'(busy), int'(m_busy));
    chk("m_err", int'(ack_err), int'(m_err));
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sel();
    btn_sel = 1'b1;
    tick(1);
    btn_sel = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(2);
    chk("rst_flag", int'(next_stage_flag), 0);
    chk("rst_sel", int'(sel_stage), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(ack_err), 0);
    reset = 1'b1;
    tick(2);

    pulse_sel();
    chk("sel_2", int'(sel_stage), 2);
    pulse_sel();
    chk("sel_3", int'(sel_stage), 3);

    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(1);
    chk("start_e2", int'(next_stage_flag), 0);
    tick(1);
    chk("start_e3", int'(next_stage_flag), 3);
    chk("start_busy", int'(busy), 1);
    tick(1);
    chk("start_hold", int'(next_stage_flag), 3);
    cur_stage = 3'd3;
    tick(1);
    chk("start_ack", int'(next_stage_flag), 0);
    chk("start_idle", int'(busy), 0);

    cur_stage = 3'd2;
    stage_end = 1'b1;
    tick(1);
    chk("s2_end", int'(next_stage_flag), 5);
    stage_end = 1'b0;
    tick(1);
    cur_stage = 3'd4;
    tick(1);
    chk("s2_ack", int'(next_stage_flag), 0);

    tick(7);
    chk("fin_7", int'(next_stage_flag), 0);
    tick(1);
    chk("fin_8", int'(next_stage_flag), 7);
    cur_stage = 3'd0;
    tick(1);
    chk("fin_ack", int'(next_stage_flag), 0);

    cur_stage = 3'd1;
    stage_end = 1'b1;
    tick(1);
    chk("to_issue", int'(next_stage_flag), 4);
    stage_end = 1'b0;
    tick(3);
    chk("to_hold", int'(next_stage_flag), 4);
    chk("to_noerr", int'(ack_err), 0);
    tick(1);
    chk("to_clear", int'(next_stage_flag), 0);
    chk("to_err", int'(ack_err), 1);
    tick(1);
    chk("to_pulse", int'(ack_err), 0);
    stage_end = 1'b1;
    tick(1);
    chk("to_reissue", int'(next_stage_flag), 4);
    stage_end = 1'b0;
    cur_stage = 3'd4;
    tick(1);
    chk("to_ack", int'(next_stage_flag), 0);
    cur_stage = 3'd0;
    tick(1);

    pulse_sel();
    pulse_sel();
    chk("sel_wrap2", int'(sel_stage), 2);

    btn_start = 1'b1;
    btn_sel = 1'b1;
    tick(1);
    btn_start = 1'b0;
    btn_sel = 1'b0;
    tick(2);
    chk("both_flag", int'(next_stage_flag), 2);
    chk("both_sel", int'(sel_stage), 2);
    btn_sel = 1'b1;
    btn_start = 1'b1;
    tick(1);
    btn_sel = 1'b0;
    btn_start = 1'b0;
    tick(2);
    chk("drop_flag", int'(next_stage_flag), 2);
    chk("drop_sel", int'(sel_stage), 2);
    tick(3);
    chk("drop_after", int'(next_stage_flag), 0);
    chk("drop_sel2", int'(sel_stage), 2);

    cur_stage = 3'd5;
    stage_end = 1'b1;
    tick(3);
    chk("bad_stage", int'(next_stage_flag), 0);
    stage_end = 1'b0;
    cur_stage = 3'd0;
    tick(1);

    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(2);
    chk("mid_issue", int'(next_stage_flag), 2);
    reset = 1'b0;
    #1;
    chk("mid_flag", int'(next_stage_flag), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_sel", int'(sel_stage), 1);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("post_flag", int'(next_stage_flag), 0);
    chk("post_sel", int'(sel_stage), 1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
